// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump engine: FSM state encoding
// and word/byte sizing helpers.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_INST_SZ    = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_INST_SZ / 8;

  function automatic int unsigned bytes_per_word(input int unsigned inst_sz);
    return inst_sz / 8;
  endfunction

endpackage

// File: rtl/mem_dump_if.sv
// Handshake bundle between the dump engine, the MEM-stage debug port and
// the UART transmitter.
interface mem_dump_if #(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned MEM_SZ  = 5
);

  logic               start;
  logic [MEM_SZ-1:0]  debug_addr;
  logic [INST_SZ-1:0] debug_mem;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done;
  logic               busy;
  logic               done;

  // master: the dump engine; slave: the surrounding MEM stage / UART side
  modport master (
    input  start, debug_mem, tx_done,
    output debug_addr, tx_data, tx_start, busy, done
  );

  modport slave (
    output start, debug_mem, tx_done,
    input  debug_addr, tx_data, tx_start, busy, done
  );

endinterface

// File: rtl/mem_dump.sv
// Streams the whole data memory out over a byte-wide UART handshake,
// word by word in ascending address order, most significant byte first.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned MEM_SZ  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [MEM_SZ-1:0]  o_debug_addr,
  input  logic [INST_SZ-1:0] i_debug_mem,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned BPW = bytes_per_word(INST_SZ);
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  state_e             state_q;
  logic [MEM_SZ-1:0]  word_q;
  logic [BCW-1:0]     byte_q;
  logic [INST_SZ-1:0] shift_q;
  logic [INST_SZ-1:0] shift_d;
  logic               tx_start_q;
  logic               busy_q;
  logic               done_q;

  assign shift_d = shift_q << 8;

  // The word counter doubles as the debug address; the byte on the wire is
  // always the top byte of the shift register, so it holds until the next shift.
  assign o_debug_addr = word_q;
  assign o_tx_data    = shift_q[INST_SZ-1 -: 8];
  assign o_tx_start   = tx_start_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            word_q  <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: state_q <= ST_LOAD;
        ST_LOAD: begin
          shift_q    <= i_debug_mem;
          tx_start_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (i_tx_done) begin
            if (byte_q != LAST_BYTE) begin
              shift_q    <= shift_d;
              byte_q     <= byte_q + BCW'(1);
              tx_start_q <= 1'b1;
              state_q    <= ST_SEND;
            end else if (word_q != '1) begin
              word_q  <= word_q + MEM_SZ'(1);
              byte_q  <= '0;
              state_q <= ST_ADDR;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          word_q  <= '0;
          byte_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: byte-stream scoreboard built from the
// memory image, plus directed handshake, reset and parameter scenarios.
module tb_mem_dump;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_dump_if #(.INST_SZ(32), .MEM_SZ(5)) bus ();
  mem_dump_if #(.INST_SZ(16), .MEM_SZ(2)) bus2 ();

  mem_dump #(.INST_SZ(32), .MEM_SZ(5)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (bus.start),
    .o_debug_addr (bus.debug_addr),
    .i_debug_mem  (bus.debug_mem),
    .o_tx_data    (bus.tx_data),
    .o_tx_start   (bus.tx_start),
    .i_tx_done    (bus.tx_done),
    .o_busy       (bus.busy),
    .o_done       (bus.done)
  );

  mem_dump #(.INST_SZ(16), .MEM_SZ(2)) dut16 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (bus2.start),
    .o_debug_addr (bus2.debug_addr),
    .i_debug_mem  (bus2.debug_mem),
    .o_tx_data    (bus2.tx_data),
    .o_tx_start   (bus2.tx_start),
    .i_tx_done    (bus2.tx_done),
    .o_busy       (bus2.busy),
    .o_done       (bus2.done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory models: registered read (one cycle latency) for the 32-bit
  // instance, combinational read for the 16-bit one.
  logic [31:0] mem1 [32];
  logic [15:0] mem2 [4];
  logic [31:0] rd1;
  always @(posedge clk) rd1 <= mem1[bus.debug_addr];
  assign bus.debug_mem  = rd1;
  assign bus2.debug_mem = mem2[bus2.debug_addr];

  logic resp_done;
  logic spur_done;
  assign bus.tx_done = resp_done | spur_done;

  int arm_cnt = 0;
  int abort_cnt = 0;
  int rx_cnt = 0;
  int done_cnt = 0;
  int stall_hits = 0;
  bit gap_en = 1'b0;
  bit stall_en = 1'b0;
  bit spur_en = 1'b0;
  logic [7:0] rx [256];

  int rx2_cnt = 0;
  int done2_cnt = 0;
  logic [7:0] rx2 [16];

  // Scoreboard / compare process for the 32-bit instance.
  initial begin
    logic [7:0] exp_q [$];
    int arm_seen, abort_seen, cyc, last_pulse;
    bit prev_start, prev_done, active;
    arm_seen = 0; abort_seen = 0; cyc = 0; last_pulse = 0;
    prev_start = 1'b0; prev_done = 1'b0; active = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (abort_cnt != abort_seen) begin
        abort_seen = abort_cnt;
        exp_q.delete();
        active = 1'b0;
      end
      if (arm_cnt != arm_seen) begin
        arm_seen = arm_cnt;
        exp_q.delete();
        rx_cnt = 0;
        active = 1'b1;
        for (int i = 0; i < 32; i++)
          for (int b = 0; b < 4; b++)
            exp_q.push_back(8'(mem1[i] >> (8 * (3 - b))));
      end
      if (bus.tx_start) begin
        chk("tx_start_width", 32'(prev_start), 0);
        if (exp_q.size() == 0) chk("stray_tx_start", 32'(bus.tx_start), 0);
        else chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        if (gap_en && rx_cnt > 0)
          chk("tx_start_gap", cyc - last_pulse, (rx_cnt % 4 == 0) ? 8 : 6);
        last_pulse = cyc;
        if (rx_cnt < 256) rx[rx_cnt] = bus.tx_data;
        rx_cnt++;
      end
      if (bus.done) begin
        chk("done_while_active", 32'(active), 1);
        chk("done_width", 32'(prev_done), 0);
        chk("done_busy_low", 32'(bus.busy), 0);
        chk("done_byte_count", rx_cnt, 128);
        done_cnt++;
        active = 1'b0;
      end
      prev_start = bus.tx_start;
      prev_done  = bus.done;
    end
  end

  // UART stand-in: tx_done five cycles after each tx_start, with optional
  // long stall and optional tx_done held through ADDR/LOAD after a word.
  initial begin
    int resp_n, arm_seen, dly;
    logic [7:0] held;
    resp_n = 0; arm_seen = 0;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (arm_cnt != arm_seen) begin
        arm_seen = arm_cnt;
        resp_n = 0;
      end
      if (bus.tx_start) begin
        held = bus.tx_data;
        dly = 5;
        if (stall_en && stall_hits == 0 && resp_n == 5) begin
          dly = 100;
          stall_hits++;
        end
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (dly == 100) begin
            chk("stall_tx_start", 32'(bus.tx_start), 0);
            chk("stall_tx_data", 32'(bus.tx_data), 32'(held));
            chk("stall_debug_addr", 32'(bus.debug_addr), 1);
          end
        end
        resp_done = 1'b1;
        if (spur_en && resp_n % 4 == 3) begin
          @(negedge clk);
          @(negedge clk);
        end
        @(posedge clk);
        #1 resp_done = 1'b0;
        resp_n++;
      end
    end
  end

  // Collector and responder for the 16-bit instance.
  initial begin
    bus2.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus2.tx_start) begin
        if (rx2_cnt < 16) rx2[rx2_cnt] = bus2.tx_data;
        rx2_cnt++;
        @(negedge clk);
        @(negedge clk);
        bus2.tx_done = 1'b1;
        @(posedge clk);
        #1 bus2.tx_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus2.done) done2_cnt++;
    end
  end

  task automatic start_dump(input bit arm);
    @(negedge clk);
    if (arm) arm_cnt++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    chk(nm, 32'(seen), 1);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (rx_cnt >= n) seen = 1'b1;
    end
    chk(nm, 32'(seen), 1);
  endtask

  initial begin
    logic [7:0] exp16 [8];
    bit seen;
    exp16 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    rst = 1'b1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    spur_done = 1'b0;
    for (int i = 0; i < 32; i++) mem1[i] = 32'hA0B0C000 + 32'(i);
    mem2 = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_debug_addr", 32'(bus.debug_addr), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst16_busy", 32'(bus2.busy), 0);
    rst = 1'b0;

    // 16-bit words, 4-deep memory
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done2_cnt != 0) seen = 1'b1;
    end
    chk("p16_done", 32'(seen), 1);
    chk("p16_byte_count", rx2_cnt, 8);
    for (int i = 0; i < 8; i++) chk("p16_byte", 32'(rx2[i]), 32'(exp16[i]));

    // Full dump with pulse-spacing checks
    chk("idle_busy", 32'(bus.busy), 0);
    gap_en = 1'b1;
    start_dump(1'b1);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("addr_first_word", 32'(bus.debug_addr), 0);
    wait_done("full_dump_done");
    gap_en = 1'b0;
    chk("full_first_byte", 32'(rx[0]), 32'h A0);
    chk("full_byte3", 32'(rx[3]), 32'h00);
    chk("full_byte7", 32'(rx[7]), 32'h01);
    chk("full_byte126", 32'(rx[126]), 32'hC0);
    chk("full_last_byte", 32'(rx[127]), 32'h1F);
    @(negedge clk);
    chk("idle_addr_zero", 32'(bus.debug_addr), 0);
    chk("idle_busy_after", 32'(bus.busy), 0);

    // Handshake stall on byte 5 (word 1)
    stall_en = 1'b1;
    start_dump(1'b1);
    wait_done("stall_dump_done");
    stall_en = 1'b0;
    chk("stall_happened", stall_hits, 1);

    // Spurious start / tx_done
    spur_en = 1'b1;
    @(negedge clk);
    arm_cnt++;
    bus.start = 1'b1;
    spur_done = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    spur_done = 1'b0;
    wait_bytes(10, "spur_reach_byte10");
    start_dump(1'b0);
    wait_done("spur_dump_done");
    spur_en = 1'b0;

    // Reset in the middle of a dump
    start_dump(1'b1);
    wait_bytes(37, "reach_byte37");
    #2 rst = 1'b1;
    abort_cnt++;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_debug_addr", 32'(bus.debug_addr), 0);
    chk("abort_tx_start", 32'(bus.tx_start), 0);
    chk("abort_done", 32'(bus.done), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_hold_tx_start", 32'(bus.tx_start), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_abort_busy", 32'(bus.busy), 0);
      chk("post_abort_done", 32'(bus.done), 0);
    end
    start_dump(1'b1);
    wait_done("restart_done");
    chk("restart_first_byte", 32'(rx[0]), 32'hA0);
    chk("restart_last_byte", 32'(rx[127]), 32'h1F);

    // Back-to-back: start in the done cycle is ignored, one later is taken
    start_dump(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk("b2b_first_done", 32'(seen), 1);
    bus.start = 1'b1;
    @(negedge clk);
    chk("b2b_start_in_done_ignored", 32'(bus.busy), 0);
    chk("b2b_idle_addr", 32'(bus.debug_addr), 0);
    arm_cnt++;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_second_start", 32'(bus.busy), 1);
    wait_done("b2b_second_done");
    chk("b2b_first_byte", 32'(rx[0]), 32'hA0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 The block SHALL have parameter INST_SZ, default 32, meaning data-memory word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter MEM_SZ, default 5, meaning data-memory address width; depth is 2^MEM_SZ words.
REQ-003 The block SHALL have a single clock, i_clk (input, 1 bit), and every register SHALL be clocked on its rising edge.
REQ-004 The block SHALL have i_reset (input, 1 bit), asynchronous and active-high.
REQ-005 The block SHALL have i_start (input, 1 bit): a one-cycle pulse that requests a full data-memory dump.
REQ-006 The block SHALL have o_debug_addr (output, MEM_SZ bits), driven to the MEM stage debug address port.
REQ-007 The block SHALL have i_debug_mem (input, INST_SZ bits), the debug read data returned by the MEM stage.
REQ-008 The block SHALL have o_tx_data (output, 8 bits), the byte presented to the UART transmitter.
REQ-009 The block SHALL have o_tx_start (output, 1 bit): a one-cycle pulse meaning o_tx_data is valid and should be sent.
REQ-010 The block SHALL have i_tx_done (input, 1 bit): a one-cycle pulse from the UART transmitter meaning the byte has been sent.
REQ-011 The block SHALL have o_busy (output, 1 bit), high whenever a dump is in progress.
REQ-012 The block SHALL have o_done (output, 1 bit): a one-cycle pulse after the last byte of a dump has been sent.

Function
REQ-013 The FSM SHALL have the states IDLE, ADDR, LOAD, SEND, WAIT and DONE.
REQ-014 In IDLE, an i_start pulse SHALL clear the word and byte counters and move the FSM to ADDR; o_busy SHALL rise in the next cycle.
REQ-015 In ADDR, o_debug_addr SHALL equal the word counter, and the FSM SHALL stay exactly one cycle; this covers a debug read of up to one cycle latency.
REQ-016 In LOAD, i_debug_mem SHALL be captured into an INST_SZ-bit shift register, and the FSM SHALL move to SEND.
REQ-017 In SEND, o_tx_start SHALL be high for exactly one cycle with o_tx_data equal to shift_reg[INST_SZ-1 -: 8]; the FSM SHALL then move to WAIT.
REQ-018 The byte order of each word SHALL be MSB first, giving INST_SZ/8 bytes per word.
REQ-019 o_tx_data SHALL remain stable from SEND until i_tx_done is accepted.
REQ-020 In WAIT, on i_tx_done:
- if more bytes remain in the word: shift left by 8, increment the byte counter, go to SEND;
- else if more words remain: increment the word counter, go to ADDR;
- else: go to DONE.
REQ-021 Words SHALL be dumped in ascending address order from 0 to 2^MEM_SZ-1; the last word SHALL terminate the dump, and the word counter SHALL NOT wrap back to address 0.
REQ-022 DONE SHALL last one cycle with o_done=1 and o_busy=0, then return to IDLE.
REQ-023 Total transfer SHALL be 2^MEM_SZ*(INST_SZ/8) bytes, which is 128 bytes at the defaults.
REQ-024 i_start SHALL be ignored in every state other than IDLE, including DONE.
REQ-025 i_tx_done SHALL be ignored in every state other than WAIT.
REQ-026 A start and a tx_done in the same cycle SHALL each be handled under its own state rule, with no interaction between them.
REQ-027 o_debug_addr SHALL hold the last word address while WAIT/SEND are active, and SHALL return to 0 in IDLE.
REQ-028 In steady state (no i_tx_done stall), consecutive o_tx_start pulses SHALL be 1 cycle + the WAIT duration apart within a word, and 3 cycles + the WAIT duration apart across a word boundary.

Reset
REQ-029 On i_reset assertion, the block SHALL immediately clear everything:
- state=IDLE;
- o_debug_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0;
- counters and shift register=0.
REQ-030 A reset during a dump SHALL abort it with no further o_tx_start and no o_done; after reset release, the block SHALL wait for a new i_start.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the BYTES_PER_WORD = INST_SZ/8 constant.
REQ-032 The block SHALL be implemented as a single module with no sub-module; the UART transmitter and the MEM stage are external.

Verification
REQ-033 Full dump: the bench SHALL preload mem[i]=32'hA0B0C000+i, pulse i_start, and answer each tx_start with tx_done after 5 cycles; the required response is 128 bytes A0,B0,C0,00,A0,B0,C0,01,...,A0,B0,C0,1F, then one o_done pulse.
REQ-034 Handshake stall: with i_tx_done withheld for 100 cycles, o_tx_start SHALL pulse once and o_tx_data SHALL stay constant for all 100 cycles.
REQ-035 Spurious inputs: a second i_start mid-dump and stray i_tx_done pulses in IDLE/ADDR/LOAD SHALL leave the byte stream unchanged and the count at exactly 128.
REQ-036 Reset mid-operation: asserting i_reset after byte 37 SHALL immediately give o_busy=0 and o_debug_addr=0, with no further tx_start; a new i_start SHALL restart the dump from address 0, byte A0.
REQ-037 Back-to-back dumps: an i_start in the o_done cycle SHALL be ignored, while an i_start one cycle later SHALL begin a new dump.
REQ-038 Parameter check: with INST_SZ=16 and MEM_SZ=2, mem={1234,5678,9ABC,DEF0} SHALL produce the bytes 12,34,56,78,9A,BC,DE,F0.
